// File: rtl/soc_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : soc_sysid_checker
// Description : Avalon-MM master that reads the two-word system-ID slave
//               (word 0 = system ID, word 1 = build timestamp) on request,
//               compares both words against build-time values and reports
//               pass/fail, timeout and the captured words.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h6220_5050,
    parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD_ID = 2'd1,
        S_RD_TS = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_address;
    logic        r_read;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic [15:0] r_wait_cnt;

    logic [15:0] w_cnt_inc;
    logic        w_tmo_hit;
    logic        w_id_match;
    logic        w_ts_match;

    // Saturating wait counter step, and the stall that would be the W-th in a row
    always_comb begin
        w_cnt_inc  = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : (r_wait_cnt + 16'd1);
        w_tmo_hit  = (TIMEOUT_CYCLES != 16'd0) &&
                     (({1'b0, r_wait_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});
        w_id_match = (avm_readdata == EXPECTED_ID);
        w_ts_match = (avm_readdata == EXPECTED_TIMESTAMP);
    end

    // Control FSM with all bus and status outputs registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_address  <= 1'b0;
            r_read     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
            r_wait_cnt <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RD_ID;
                        r_read     <= 1'b1;
                        r_address  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_id_ok    <= 1'b0;
                        r_ts_ok    <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_id_value <= 32'd0;
                        r_ts_value <= 32'd0;
                        r_wait_cnt <= 16'd0;
                    end
                end
                S_RD_ID: begin
                    if (!avm_waitrequest) begin
                        r_id_value <= avm_readdata;
                        r_id_ok    <= w_id_match;
                        r_wait_cnt <= 16'd0;
                        r_address  <= 1'b1;
                        r_state    <= S_RD_TS;
                    end else if (w_tmo_hit) begin
                        r_timeout  <= 1'b1;
                        r_pass     <= 1'b0;
                        r_done     <= 1'b1;
                        r_read     <= 1'b0;
                        r_address  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_wait_cnt <= w_cnt_inc;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                S_RD_TS: begin
                    if (!avm_waitrequest) begin
                        r_ts_value <= avm_readdata;
                        r_ts_ok    <= w_ts_match;
                        r_pass     <= r_id_ok & w_ts_match;
                        r_done     <= 1'b1;
                        r_read     <= 1'b0;
                        r_address  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_wait_cnt <= 16'd0;
                        r_state    <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        r_timeout  <= 1'b1;
                        r_pass     <= 1'b0;
                        r_done     <= 1'b1;
                        r_read     <= 1'b0;
                        r_address  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_wait_cnt <= w_cnt_inc;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_read    <= 1'b0;
                    r_address <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address = r_address;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
`default_nettype wire
